// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with load-use and branch-operand hazard detection.
// Holds on a hazard, flushes to a bubble on a taken branch/jump, and counts stalls and flushes.
module if_id_stage #(
    parameter logic [31:0] NOP_WORD = 32'h00000000,
    parameter int          CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [31:0]      FetchInstr,
    input  logic [31:0]      FetchPC,
    input  logic             PCSrc,
    input  logic             IdExMemRead,
    input  logic             IdExRegWrite,
    input  logic [4:0]       IdExDestReg,
    input  logic             ExMemMemRead,
    input  logic [4:0]       ExMemDestReg,
    output logic [31:0]      IfIdInstr,
    output logic [31:0]      IfIdPCPlus4,
    output logic             IfIdValid,
    output logic             stallDetector,
    output logic             BubbleToEx,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic       is_br;
    logic       match_ex;
    logic       match_mem;
    logic       hazard;

    assign op    = IfIdInstr[31:26];
    assign rs    = IfIdInstr[25:21];
    assign rt    = IfIdInstr[20:16];
    assign funct = IfIdInstr[5:0];

    always_comb begin
        uses_rs   = (op != 6'd2) && (op != 6'd3);
        uses_rt   = (op == 6'd0) || (op == 6'd4) || (op == 6'd5) || (op == 6'h2B);
        is_br     = (op == 6'd4) || (op == 6'd5) || ((op == 6'd0) && (funct == 6'h08));
        match_ex  = (IdExDestReg != 5'd0) &&
                    ((uses_rs && rs == IdExDestReg) || (uses_rt && rt == IdExDestReg));
        match_mem = (ExMemDestReg != 5'd0) &&
                    ((uses_rs && rs == ExMemDestReg) || (uses_rt && rt == ExMemDestReg));
        // A bubble in IF/ID never stalls, whatever its field bits decode to
        hazard    = IfIdValid && ((IdExMemRead && match_ex) ||
                                  (is_br && IdExRegWrite && match_ex) ||
                                  (is_br && ExMemMemRead && match_mem));
    end

    assign stallDetector = ~hazard;
    assign BubbleToEx    = hazard;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            IfIdInstr   <= NOP_WORD;
            IfIdPCPlus4 <= 32'd0;
            IfIdValid   <= 1'b0;
            StallCount  <= '0;
            FlushCount  <= '0;
        end else if (PCSrc) begin
            IfIdInstr <= NOP_WORD;
            IfIdValid <= 1'b0;
            if (~&FlushCount) FlushCount <= FlushCount + CNT_W'(1);
        end else if (hazard) begin
            if (~&StallCount) StallCount <= StallCount + CNT_W'(1);
        end else begin
            IfIdInstr   <= FetchInstr;
            IfIdPCPlus4 <= FetchPC + 32'd4;
            IfIdValid   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed scoreboard bench for if_id_stage, with a 4-bit counter instance for saturation.
module tb_if_id_stage;
    localparam logic [31:0] ADD  = 32'h01335020;
    localparam logic [31:0] NEXT = 32'h02328820;
    localparam logic [31:0] BEQ  = 32'h112A0001;
    localparam logic [31:0] ZR   = 32'h00005020;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        stall_n;
        logic [15:0] scnt;
        logic [15:0] fcnt;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] FetchInstr;
    logic [31:0] FetchPC;
    logic        PCSrc;
    logic        IdExMemRead;
    logic        IdExRegWrite;
    logic [4:0]  IdExDestReg;
    logic        ExMemMemRead;
    logic [4:0]  ExMemDestReg;
    logic [31:0] IfIdInstr;
    logic [31:0] IfIdPCPlus4;
    logic        IfIdValid;
    logic        stallDetector;
    logic        BubbleToEx;
    logic [15:0] StallCount;
    logic [15:0] FlushCount;
    logic [31:0] instr_4;
    logic [31:0] pc4_4;
    logic        valid_4;
    logic        stall_4;
    logic        bubble_4;
    logic [3:0]  scnt_4;
    logic [3:0]  fcnt_4;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 Clk = ~Clk;

    if_id_stage dut (
        .Clk(Clk), .Rst(Rst), .FetchInstr(FetchInstr), .FetchPC(FetchPC), .PCSrc(PCSrc),
        .IdExMemRead(IdExMemRead), .IdExRegWrite(IdExRegWrite), .IdExDestReg(IdExDestReg),
        .ExMemMemRead(ExMemMemRead), .ExMemDestReg(ExMemDestReg),
        .IfIdInstr(IfIdInstr), .IfIdPCPlus4(IfIdPCPlus4), .IfIdValid(IfIdValid),
        .stallDetector(stallDetector), .BubbleToEx(BubbleToEx),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    if_id_stage #(.CNT_W(4)) dut4 (
        .Clk(Clk), .Rst(Rst), .FetchInstr(FetchInstr), .FetchPC(FetchPC), .PCSrc(PCSrc),
        .IdExMemRead(IdExMemRead), .IdExRegWrite(IdExRegWrite), .IdExDestReg(IdExDestReg),
        .ExMemMemRead(ExMemMemRead), .ExMemDestReg(ExMemDestReg),
        .IfIdInstr(instr_4), .IfIdPCPlus4(pc4_4), .IfIdValid(valid_4),
        .stallDetector(stall_4), .BubbleToEx(bubble_4),
        .StallCount(scnt_4), .FlushCount(fcnt_4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge state, then compare after the edge
    task automatic step(input logic rst, input logic [31:0] instr, input logic [31:0] pc,
                        input logic pcsrc, input logic mr, input logic rw, input logic [4:0] d,
                        input logic emr, input logic [4:0] ed,
                        input logic [31:0] e_instr, input logic [31:0] e_pc4, input logic e_valid,
                        input logic e_stall_n, input logic [15:0] e_scnt, input logic [15:0] e_fcnt);
        exp_t e;
        Rst = rst; FetchInstr = instr; FetchPC = pc; PCSrc = pcsrc;
        IdExMemRead = mr; IdExRegWrite = rw; IdExDestReg = d;
        ExMemMemRead = emr; ExMemDestReg = ed;
        exp_q.push_back('{e_instr, e_pc4, e_valid, e_stall_n, e_scnt, e_fcnt});
        @(posedge Clk);
        #1;
        e = exp_q.pop_front();
        chk("instr", IfIdInstr, e.instr);
        chk("pc4", IfIdPCPlus4, e.pc4);
        chk("valid", {31'd0, IfIdValid}, {31'd0, e.valid});
        chk("stall_n", {31'd0, stallDetector}, {31'd0, e.stall_n});
        chk("bubble", {31'd0, BubbleToEx}, {31'd0, ~e.stall_n});
        chk("stall_cnt", {16'd0, StallCount}, {16'd0, e.scnt});
        chk("flush_cnt", {16'd0, FlushCount}, {16'd0, e.fcnt});
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset held two cycles with all-ones on fetch
        step(1, 32'hFFFFFFFF, 32'h0, 0, 0, 0, 0, 0, 0,  32'h0, 32'h0, 0, 1, 0, 0);
        step(1, 32'hFFFFFFFF, 32'h0, 0, 0, 0, 0, 0, 0,  32'h0, 32'h0, 0, 1, 0, 0);
        // load-use: add after lw $t1
        step(0, ADD,  32'h100, 0, 0, 0, 0, 0, 0,  ADD,  32'h104, 1, 1, 0, 0);
        step(0, NEXT, 32'h104, 0, 1, 1, 9, 0, 0,  ADD,  32'h104, 1, 0, 1, 0);
        step(0, NEXT, 32'h104, 0, 0, 0, 0, 0, 0,  NEXT, 32'h108, 1, 1, 1, 0);
        // branch after load: EX stage then MEM stage, two stall cycles
        step(0, BEQ,  32'h200, 0, 0, 0, 0, 0, 0,  BEQ,  32'h204, 1, 1, 1, 0);
        step(0, ADD,  32'h300, 0, 1, 1, 9, 0, 0,  BEQ,  32'h204, 1, 0, 2, 0);
        step(0, ADD,  32'h300, 0, 0, 0, 0, 1, 9,  BEQ,  32'h204, 1, 0, 3, 0);
        step(0, ADD,  32'h300, 0, 0, 0, 0, 0, 0,  ADD,  32'h304, 1, 1, 3, 0);
        // flush wins over a load-use hazard; the resulting bubble does not stall
        step(0, BEQ,  32'h400, 1, 1, 1, 9, 0, 0,  32'h0, 32'h304, 0, 1, 3, 1);
        step(0, ADD,  32'h400, 0, 0, 0, 0, 0, 0,  ADD,  32'h404, 1, 1, 3, 1);
        // $0 destination never stalls
        step(0, ZR,   32'h500, 0, 0, 0, 0, 0, 0,  ZR,   32'h504, 1, 1, 3, 1);
        step(0, ADD,  32'h504, 0, 1, 1, 0, 1, 0,  ADD,  32'h508, 1, 1, 3, 1);
        // PC+4 wraps at the top of the address space
        step(0, BEQ,  32'hFFFFFFFC, 0, 0, 0, 0, 0, 0,  BEQ, 32'h0, 1, 1, 3, 1);
        // branch after an ALU producer of rt stalls one cycle
        step(0, ADD,  32'h10, 0, 0, 1, 10, 0, 0,  BEQ, 32'h0, 1, 0, 4, 1);
        step(0, ADD,  32'h10, 0, 0, 0, 0, 0, 0,   ADD, 32'h14, 1, 1, 4, 1);
        // a non-branch after an ALU producer does not stall
        step(0, NEXT, 32'h14, 0, 0, 1, 9, 0, 0,   NEXT, 32'h18, 1, 1, 4, 1);
        // saturation: 20 load-use stalls from a fresh reset
        step(1, NEXT, 32'h0, 0, 0, 0, 0, 0, 0,    32'h0, 32'h0, 0, 1, 0, 0);
        step(0, ADD,  32'h20, 0, 0, 0, 0, 0, 0,   ADD, 32'h24, 1, 1, 0, 0);
        for (int i = 1; i <= 20; i++)
            step(0, NEXT, 32'h24, 0, 1, 0, 9, 0, 0,  ADD, 32'h24, 1, 0, 16'(i), 0);
        chk("sat_cnt4", {28'd0, scnt_4}, 32'hF);
        step(1, NEXT, 32'h24, 0, 1, 0, 9, 0, 0,  32'h0, 32'h0, 0, 1, 0, 0);
        chk("rst_cnt4", {28'd0, scnt_4}, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
